// File: rtl/ttl_pkg.sv
// Shared helpers for the synchronous TTL part models.
package ttl_pkg;

  localparam int TTL_SYNC_MAX = 3;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/ttl_sync.sv
// N-stage resettable synchronizer; STAGES=0 degenerates to a wire.
module ttl_sync #(
  parameter int   STAGES    = 0,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  generate
    if (STAGES == 0) begin : g_wire
      logic unused_s;
      assign unused_s = CLK ^ RST;
      assign q        = d;
    end else begin : g_flops
      logic [STAGES-1:0] sync_r;

      // Synchronizer chain, preset to RESET_VAL so a high input causes no edge on release.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          sync_r <= {STAGES{RESET_VAL}};
        end else begin
          sync_r[0] <= d;
          for (int i = 1; i < STAGES; i++) begin
            sync_r[i] <= sync_r[i-1];
          end
        end
      end

      assign q = sync_r[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/ls165_sync.sv
// LS165 parallel-in/serial-out shift register on a single system clock.
// Board shift clock, inhibit and load strobes are sampled and edge-detected on CLK.
module ls165_sync
  import ttl_pkg::*;
#(
  parameter  int WIDTH       = 8,
  parameter  int SYNC_STAGES = 0,
  localparam int CW          = clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLK2,
  input  logic             INH,
  input  logic             SH_nLD,
  input  logic [WIDTH-1:0] D,
  input  logic             SER,
  output logic             QH,
  output logic             nQH,
  output logic [CW-1:0]    SHIFT_CNT
);

  localparam int            SYNC_N  = (SYNC_STAGES > TTL_SYNC_MAX) ? TTL_SYNC_MAX : SYNC_STAGES;
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic             s_clk2_s;
  logic             s_inh_s;
  logic             s_nld_s;
  logic             gclk_s;
  logic             shift_ev_s;
  logic             prev_gclk_r;
  logic [WIDTH-1:0] shift_r;
  logic [WIDTH-1:0] shift_nxt_s;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    cnt_nxt_s;
  logic             nqh_r;

  ttl_sync #(.STAGES(SYNC_N), .RESET_VAL(1'b1)) u_sync_clk2 (
    .CLK(CLK), .RST(RST), .d(CLK2), .q(s_clk2_s)
  );
  ttl_sync #(.STAGES(SYNC_N), .RESET_VAL(1'b1)) u_sync_inh (
    .CLK(CLK), .RST(RST), .d(INH), .q(s_inh_s)
  );
  ttl_sync #(.STAGES(SYNC_N), .RESET_VAL(1'b1)) u_sync_nld (
    .CLK(CLK), .RST(RST), .d(SH_nLD), .q(s_nld_s)
  );

  // INH is ORed into the shift clock, so a rising INH with CLK2 low also shifts.
  assign gclk_s     = s_clk2_s | s_inh_s;
  assign shift_ev_s = gclk_s & ~prev_gclk_r & s_nld_s;

  // Next register/counter: level-sensitive load dominates, then a qualified shift.
  always_comb begin
    shift_nxt_s = shift_r;
    cnt_nxt_s   = cnt_r;
    if (!s_nld_s) begin
      shift_nxt_s = D;
      cnt_nxt_s   = '0;
    end else if (shift_ev_s) begin
      shift_nxt_s = {shift_r[WIDTH-2:0], SER};
      if (cnt_r == CNT_MAX) begin
        cnt_nxt_s = cnt_r;
      end else begin
        cnt_nxt_s = cnt_r + CW'(1);
      end
    end else begin
      shift_nxt_s = shift_r;
      cnt_nxt_s   = cnt_r;
    end
  end

  // State update; nQH is registered from the same next value so it always mirrors QH.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shift_r     <= '0;
      cnt_r       <= '0;
      prev_gclk_r <= 1'b1;
      nqh_r       <= 1'b1;
    end else begin
      shift_r     <= shift_nxt_s;
      cnt_r       <= cnt_nxt_s;
      prev_gclk_r <= gclk_s;
      nqh_r       <= ~shift_nxt_s[WIDTH-1];
    end
  end

  assign QH        = shift_r[WIDTH-1];
  assign nQH       = nqh_r;
  assign SHIFT_CNT = cnt_r;

endmodule

// File: tb/tb_ls165_sync.sv
// Directed bench for ls165_sync: one instance without synchronizers, one with two stages.
module tb_ls165_sync;

  logic       CLK;
  logic       RST;
  logic       CLK2;
  logic       INH;
  logic       SH_nLD;
  logic [7:0] D;
  logic       SER;
  logic       qh0, nqh0, qh2, nqh2;
  logic [3:0] cnt0, cnt2;

  int n_assert = 0;
  int n_fail   = 0;

  ls165_sync #(.WIDTH(8), .SYNC_STAGES(0)) dut0 (
    .CLK(CLK), .RST(RST), .CLK2(CLK2), .INH(INH), .SH_nLD(SH_nLD),
    .D(D), .SER(SER), .QH(qh0), .nQH(nqh0), .SHIFT_CNT(cnt0)
  );

  ls165_sync #(.WIDTH(8), .SYNC_STAGES(2)) dut2 (
    .CLK(CLK), .RST(RST), .CLK2(CLK2), .INH(INH), .SH_nLD(SH_nLD),
    .D(D), .SER(SER), .QH(qh2), .nQH(nqh2), .SHIFT_CNT(cnt2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // QH, nQH and SHIFT_CNT of the zero-stage instance against one expectation.
  task automatic chk0(input string tag, input logic exp_qh, input logic [3:0] exp_cnt);
    check({tag, ".qh"}, {31'd0, qh0}, {31'd0, exp_qh});
    check({tag, ".nqh"}, {31'd0, nqh0}, {31'd0, ~exp_qh});
    check({tag, ".cnt"}, {28'd0, cnt0}, {28'd0, exp_cnt});
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One CLK2 rising edge: low for a cycle, then high for a cycle.
  task automatic pulse_clk2();
    CLK2 = 1'b0;
    step();
    CLK2 = 1'b1;
    step();
  endtask

  initial begin
    logic [7:0] pat;
    logic       e_qh;
    logic [3:0] e_cnt;

    RST = 1'b1; CLK2 = 1'b1; INH = 1'b0; SH_nLD = 1'b1; D = 8'h00; SER = 1'b0;
    step();
    step();
    chk0("reset", 1'b0, 4'd0);
    check("reset.dut2.cnt", {28'd0, cnt2}, 32'd0);

    // Release with CLK2 already high: no edge may be seen.
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk0("post_reset", 1'b0, 4'd0);
    end

    // Load A5, then eight shifts with SER=0.
    D = 8'hA5; SH_nLD = 1'b0;
    step();
    SH_nLD = 1'b1;
    step();
    chk0("load_a5", 1'b1, 4'd0);
    pat = 8'hA5;
    for (int k = 1; k <= 8; k++) begin
      pulse_clk2();
      e_qh = (k < 8) ? pat[7-k] : 1'b0;
      chk0($sformatf("shift_a5_%0d", k), e_qh, 4'(k));
    end

    // Reload F0: count returns to 0.
    D = 8'hF0; SH_nLD = 1'b0;
    step();
    SH_nLD = 1'b1;
    step();
    chk0("load_f0", 1'b1, 4'd0);

    // Inhibit high masks CLK2 toggles.
    INH = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      CLK2 = ~CLK2;
      step();
    end
    chk0("inh_toggles", 1'b1, 4'd0);
    INH = 1'b0;
    step();
    chk0("inh_fall_clk2_high", 1'b1, 4'd0);
    CLK2 = 1'b0;
    step();
    INH = 1'b1;
    step();
    chk0("inh_rise", 1'b1, 4'd1);
    step();
    step();
    chk0("inh_held", 1'b1, 4'd1);
    INH = 1'b0;
    step();

    // Load is transparent to D and dominates a CLK2 rising edge.
    D = 8'h3C; SH_nLD = 1'b0; CLK2 = 1'b0;
    step();
    chk0("load_3c", 1'b0, 4'd0);
    CLK2 = 1'b1; D = 8'hC3;
    step();
    chk0("load_c3_edge", 1'b1, 4'd0);
    CLK2 = 1'b0;
    step();
    SH_nLD = 1'b1;
    step();
    chk0("load_release", 1'b1, 4'd0);
    CLK2 = 1'b1;
    step();
    chk0("shift_after_release", 1'b1, 4'd1);

    // Edge in the same cycle as load release still shifts.
    CLK2 = 1'b0; SH_nLD = 1'b0;
    step();
    SH_nLD = 1'b1; CLK2 = 1'b1;
    step();
    chk0("release_with_edge", 1'b1, 4'd1);

    // Cascade: load 00, SER=1; check the bit each shift moves out, and the count.
    D = 8'h00; SER = 1'b1; SH_nLD = 1'b0;
    step();
    SH_nLD = 1'b1;
    step();
    for (int k = 1; k <= 12; k++) begin
      CLK2 = 1'b0;
      step();
      check($sformatf("cascade_out_%0d", k), {31'd0, qh0}, {31'd0, (k >= 9)});
      CLK2 = 1'b1;
      step();
      e_cnt = (k > 8) ? 4'd8 : 4'(k);
      check($sformatf("cascade_cnt_%0d", k), {28'd0, cnt0}, {28'd0, e_cnt});
    end
    chk0("cascade_end", 1'b1, 4'd8);

    // Asynchronous reset mid-stream, released with CLK2 high.
    #2;
    RST = 1'b1;
    #1;
    chk0("async_reset", 1'b0, 4'd0);
    RST = 1'b0;
    step();
    step();
    chk0("async_release", 1'b0, 4'd0);

    // Latency: both instances loaded with 80, then one CLK2 rising edge.
    SER = 1'b0; D = 8'h80; SH_nLD = 1'b0; CLK2 = 1'b0;
    for (int i = 0; i < 4; i++) step();
    SH_nLD = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk0("lat_load0", 1'b1, 4'd0);
    check("lat_load2.qh", {31'd0, qh2}, 32'd1);
    check("lat_load2.cnt", {28'd0, cnt2}, 32'd0);
    CLK2 = 1'b1;
    step();
    chk0("lat_s0_edge1", 1'b0, 4'd1);
    check("lat_s2_edge1.qh", {31'd0, qh2}, 32'd1);
    step();
    check("lat_s2_edge2.qh", {31'd0, qh2}, 32'd1);
    check("lat_s2_edge2.cnt", {28'd0, cnt2}, 32'd0);
    step();
    check("lat_s2_edge3.qh", {31'd0, qh2}, 32'd0);
    check("lat_s2_edge3.nqh", {31'd0, nqh2}, 32'd1);
    check("lat_s2_edge3.cnt", {28'd0, cnt2}, 32'd1);
    for (int i = 0; i < 4; i++) step();
    check("lat_s2_single.cnt", {28'd0, cnt2}, 32'd1);
    chk0("lat_s0_single", 1'b0, 4'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
